// File: rtl/mem_bus_arbiter_pkg.sv
// Shared types for the fetch/data memory bus arbiter.
// Grant FSM state encoding and master indices used for round-robin history.
package mem_bus_pkg;

  typedef enum logic [1:0] {
    ARB_IDLE,
    ARB_GNT0,
    ARB_GNT1
  } arb_state_t;

  localparam int M_FETCH = 0;
  localparam int M_DATA  = 1;

endpackage

// File: rtl/mem_bus_arbiter_timeout.sv
// Ack-wait counter: expire is combinational in the cycle the count reaches LIMIT-1 while en.
// No backpressure; clr has priority over en, and LIMIT = 0 never expires.
module bus_timeout_counter #(
  parameter int WIDTH = 8,
  parameter int LIMIT = 255
) (
  input  logic clk,
  input  logic rst,
  input  logic clr,
  input  logic en,
  output logic expire
);

  localparam logic [WIDTH-1:0] LAST = WIDTH'((LIMIT > 0) ? LIMIT - 1 : 0);

  logic [WIDTH-1:0] cnt;

  assign expire = (LIMIT > 0) && en && (cnt == LAST);

  always_ff @(posedge clk) begin
    if (rst || clr || expire) begin
      cnt <= '0;
    end else if (en) begin
      cnt <= cnt + WIDTH'(1);
    end
  end

endmodule

// File: rtl/mem_bus_arbiter.sv
// Two-master Wishbone arbiter (fetch M0, data M1): 1-cycle grant, zero-latency request/ack paths.
// Owner holds the bus until its cyc drops or its ack timeout fires; the loser simply waits with cyc high.
module mem_bus_arbiter
  import mem_bus_pkg::*;
#(
  parameter int ADDR_W      = 16,
  parameter int DATA_W      = 32,
  parameter int TIMEOUT_CYC = 255
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              m0_cyc_i,
  input  logic              m0_stb_i,
  input  logic [ADDR_W-1:0] m0_adr_i,
  output logic              m0_ack_o,
  output logic              m0_err_o,
  input  logic              m1_cyc_i,
  input  logic              m1_stb_i,
  input  logic              m1_we_i,
  input  logic [ADDR_W-1:0] m1_adr_i,
  input  logic [DATA_W-1:0] m1_dat_i,
  output logic              m1_ack_o,
  output logic              m1_err_o,
  output logic              s_cyc_o,
  output logic              s_stb_o,
  output logic              s_we_o,
  output logic [ADDR_W-1:0] s_adr_o,
  output logic [DATA_W-1:0] s_dat_o,
  input  logic              s_ack_i,
  input  logic [DATA_W-1:0] s_dat_i,
  output logic [DATA_W-1:0] m_dat_o,
  output logic [1:0]        gnt_o
);

  localparam int TO_W = (TIMEOUT_CYC > 2) ? $clog2(TIMEOUT_CYC) : 1;

  arb_state_t state, state_nxt;
  logic       last_gnt;
  logic       owner_cyc, owner_stb;
  logic       rel_bus, expire, to_en, to_clr;

  always_comb begin
    owner_cyc = 1'b0;
    owner_stb = 1'b0;
    case (state)
      ARB_GNT0: begin
        owner_cyc = m0_cyc_i;
        owner_stb = m0_stb_i;
      end
      ARB_GNT1: begin
        owner_cyc = m1_cyc_i;
        owner_stb = m1_stb_i;
      end
      default: ;
    endcase
  end

  // Timeout only counts cycles the owner is actually waiting on the slave.
  assign to_en   = (state != ARB_IDLE) && owner_stb && !s_ack_i;
  assign rel_bus = (state != ARB_IDLE) && (!owner_cyc || expire);
  assign to_clr  = s_ack_i || !owner_stb || (state_nxt != state);

  bus_timeout_counter #(
    .WIDTH (TO_W),
    .LIMIT (TIMEOUT_CYC)
  ) u_timeout (
    .clk    (clk),
    .rst    (rst),
    .clr    (to_clr),
    .en     (to_en),
    .expire (expire)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      state    <= ARB_IDLE;
      last_gnt <= 1'(M_DATA);
    end else begin
      state <= state_nxt;
      if (rel_bus) begin
        last_gnt <= (state == ARB_GNT1) ? 1'(M_DATA) : 1'(M_FETCH);
      end
    end
  end

  // A releasing owner hands straight to a waiting peer, so there is no IDLE bubble.
  always_comb begin
    state_nxt = state;
    case (state)
      ARB_IDLE: begin
        if (m0_cyc_i && m1_cyc_i) begin
          state_nxt = (last_gnt == 1'(M_DATA)) ? ARB_GNT0 : ARB_GNT1;
        end else if (m0_cyc_i) begin
          state_nxt = ARB_GNT0;
        end else if (m1_cyc_i) begin
          state_nxt = ARB_GNT1;
        end
      end
      ARB_GNT0: if (rel_bus) state_nxt = m1_cyc_i ? ARB_GNT1 : ARB_IDLE;
      ARB_GNT1: if (rel_bus) state_nxt = m0_cyc_i ? ARB_GNT0 : ARB_IDLE;
      default:  state_nxt = ARB_IDLE;
    endcase
  end

  always_comb begin
    gnt_o    = 2'b00;
    s_cyc_o  = 1'b0;
    s_stb_o  = 1'b0;
    s_we_o   = 1'b0;
    s_adr_o  = '0;
    s_dat_o  = '0;
    m0_ack_o = 1'b0;
    m1_ack_o = 1'b0;
    m0_err_o = 1'b0;
    m1_err_o = 1'b0;
    case (state)
      ARB_GNT0: begin
        gnt_o    = 2'b01;
        s_cyc_o  = m0_cyc_i;
        s_stb_o  = m0_stb_i;
        s_adr_o  = m0_adr_i;
        m0_ack_o = s_ack_i & m0_stb_i;
        m0_err_o = expire;
      end
      ARB_GNT1: begin
        gnt_o    = 2'b10;
        s_cyc_o  = m1_cyc_i;
        s_stb_o  = m1_stb_i;
        s_we_o   = m1_we_i;
        s_adr_o  = m1_adr_i;
        s_dat_o  = m1_dat_i;
        m1_ack_o = s_ack_i & m1_stb_i;
        m1_err_o = expire;
      end
      default: ;
    endcase
  end

  assign m_dat_o = s_dat_i;

endmodule

// File: tb/tb_mem_bus_arbiter.sv
// Scenario bench for mem_bus_arbiter with TIMEOUT_CYC = 4.
// Per-master scoreboards hold the slave request each transfer should present when acked.
module tb_mem_bus_arbiter;

  typedef struct packed {
    logic [15:0] adr;
    logic        we;
    logic [31:0] dat;
  } xfer_t;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst;
  logic        m0_cyc_i, m0_stb_i, m0_ack_o, m0_err_o;
  logic [15:0] m0_adr_i;
  logic        m1_cyc_i, m1_stb_i, m1_we_i, m1_ack_o, m1_err_o;
  logic [15:0] m1_adr_i;
  logic [31:0] m1_dat_i;
  logic        s_cyc_o, s_stb_o, s_we_o, s_ack_i;
  logic [15:0] s_adr_o;
  logic [31:0] s_dat_o, s_dat_i, m_dat_o;
  logic [1:0]  gnt_o;

  int    total = 0;
  int    bad   = 0;
  xfer_t sb0[$];
  xfer_t sb1[$];
  xfer_t e;

  mem_bus_arbiter #(.ADDR_W(16), .DATA_W(32), .TIMEOUT_CYC(4)) dut (
    .clk(clk), .rst(rst),
    .m0_cyc_i(m0_cyc_i), .m0_stb_i(m0_stb_i), .m0_adr_i(m0_adr_i),
    .m0_ack_o(m0_ack_o), .m0_err_o(m0_err_o),
    .m1_cyc_i(m1_cyc_i), .m1_stb_i(m1_stb_i), .m1_we_i(m1_we_i),
    .m1_adr_i(m1_adr_i), .m1_dat_i(m1_dat_i),
    .m1_ack_o(m1_ack_o), .m1_err_o(m1_err_o),
    .s_cyc_o(s_cyc_o), .s_stb_o(s_stb_o), .s_we_o(s_we_o),
    .s_adr_o(s_adr_o), .s_dat_o(s_dat_o), .s_ack_i(s_ack_i), .s_dat_i(s_dat_i),
    .m_dat_o(m_dat_o), .gnt_o(gnt_o)
  );

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic smp();
    @(negedge clk);
  endtask

  task automatic idle_inputs();
    m0_cyc_i = 0; m0_stb_i = 0; m0_adr_i = '0;
    m1_cyc_i = 0; m1_stb_i = 0; m1_we_i = 0; m1_adr_i = '0; m1_dat_i = '0;
    s_ack_i = 0; s_dat_i = '0;
  endtask

  task automatic test_reset();
    idle_inputs();
    rst = 1;
    tick(); tick(); smp();
    total++; if (gnt_o !== 2'b00) begin bad++; $display("FAIL rst_gnt act=%b exp=00", gnt_o); end
    total++; if ({s_cyc_o, s_stb_o, s_we_o} !== 3'b000) begin bad++; $display("FAIL rst_ctl act=%b exp=000", {s_cyc_o, s_stb_o, s_we_o}); end
    total++; if ({s_adr_o, s_dat_o, m_dat_o} !== '0) begin bad++; $display("FAIL rst_bus act=%h/%h/%h exp=0", s_adr_o, s_dat_o, m_dat_o); end
    total++; if ({m0_ack_o, m1_ack_o, m0_err_o, m1_err_o} !== 4'b0000) begin bad++; $display("FAIL rst_ackerr act=%b exp=0000", {m0_ack_o, m1_ack_o, m0_err_o, m1_err_o}); end
    tick(); rst = 0;
  endtask

  task automatic test_fetch();
    tick(); m0_cyc_i = 1; m0_stb_i = 1; m0_adr_i = 16'h0010; sb0.push_back({16'h0010, 1'b0, 32'h0});
    smp();
    total++; if (gnt_o !== 2'b00) begin bad++; $display("FAIL fetch_c0_gnt act=%b exp=00", gnt_o); end
    tick(); smp();
    total++; if (gnt_o !== 2'b01) begin bad++; $display("FAIL fetch_c1_gnt act=%b exp=01", gnt_o); end
    total++; if (s_cyc_o !== 1'b1) begin bad++; $display("FAIL fetch_c1_cyc act=%b exp=1", s_cyc_o); end
    total++; if (s_adr_o !== 16'h0010) begin bad++; $display("FAIL fetch_c1_adr act=%h exp=0010", s_adr_o); end
    tick(); smp();
    total++; if (m0_ack_o !== 1'b0) begin bad++; $display("FAIL fetch_c2_ack act=%b exp=0", m0_ack_o); end
    tick(); s_ack_i = 1; s_dat_i = 32'hCAFE0001; smp();
    total++; if ({m0_ack_o, m1_ack_o} !== 2'b10) begin bad++; $display("FAIL fetch_c3_ack act=%b exp=10", {m0_ack_o, m1_ack_o}); end
    total++; if (m_dat_o !== 32'hCAFE0001) begin bad++; $display("FAIL fetch_rdata act=%h exp=cafe0001", m_dat_o); end
    total++; if (sb0.size() == 0) begin bad++; $display("FAIL fetch_sb act=empty exp=entry"); end
    else begin e = sb0.pop_front(); if ({s_adr_o, s_we_o, s_dat_o} !== e) begin bad++; $display("FAIL fetch_sb act=%h exp=%h", {s_adr_o, s_we_o, s_dat_o}, e); end end
    tick(); s_ack_i = 0; m0_cyc_i = 0; m0_stb_i = 0; smp();
    total++; if (s_cyc_o !== 1'b0) begin bad++; $display("FAIL fetch_c4_cyc act=%b exp=0", s_cyc_o); end
    tick(); smp();
    total++; if (gnt_o !== 2'b00) begin bad++; $display("FAIL fetch_c5_idle act=%b exp=00", gnt_o); end
  endtask

  task automatic test_contention();
    tick(); rst = 1;
    tick(); rst = 0;
    m0_cyc_i = 1; m0_stb_i = 1; m0_adr_i = 16'h0100; sb0.push_back({16'h0100, 1'b0, 32'h0});
    m1_cyc_i = 1; m1_stb_i = 1; m1_adr_i = 16'h0300; m1_dat_i = 32'h55; sb1.push_back({16'h0300, 1'b0, 32'h55});
    tick(); s_ack_i = 1; smp();
    total++; if (gnt_o !== 2'b01) begin bad++; $display("FAIL cont_first act=%b exp=01", gnt_o); end
    total++; if ({m0_ack_o, m1_ack_o} !== 2'b10) begin bad++; $display("FAIL cont_ack0 act=%b exp=10", {m0_ack_o, m1_ack_o}); end
    total++; if (sb0.size() == 0) begin bad++; $display("FAIL cont_sb0 act=empty exp=entry"); end
    else begin e = sb0.pop_front(); if ({s_adr_o, s_we_o, s_dat_o} !== e) begin bad++; $display("FAIL cont_sb0 act=%h exp=%h", {s_adr_o, s_we_o, s_dat_o}, e); end end
    tick(); s_ack_i = 0; m0_cyc_i = 0; m0_stb_i = 0; smp();
    total++; if (s_cyc_o !== 1'b0) begin bad++; $display("FAIL cont_release_cyc act=%b exp=0", s_cyc_o); end
    tick(); s_ack_i = 1; smp();
    total++; if (gnt_o !== 2'b10) begin bad++; $display("FAIL cont_handover act=%b exp=10", gnt_o); end
    total++; if ({m0_ack_o, m1_ack_o} !== 2'b01) begin bad++; $display("FAIL cont_ack1 act=%b exp=01", {m0_ack_o, m1_ack_o}); end
    total++; if (sb1.size() == 0) begin bad++; $display("FAIL cont_sb1 act=empty exp=entry"); end
    else begin e = sb1.pop_front(); if ({s_adr_o, s_we_o, s_dat_o} !== e) begin bad++; $display("FAIL cont_sb1 act=%h exp=%h", {s_adr_o, s_we_o, s_dat_o}, e); end end
    tick(); s_ack_i = 0; m1_cyc_i = 0; m1_stb_i = 0;
    tick(); smp();
    total++; if (gnt_o !== 2'b00) begin bad++; $display("FAIL cont_idle act=%b exp=00", gnt_o); end
  endtask

  task automatic test_round_robin();
    tick(); m0_cyc_i = 1; m0_stb_i = 1; m0_adr_i = 16'h0020; sb0.push_back({16'h0020, 1'b0, 32'h0});
    tick(); s_ack_i = 1; smp();
    total++; if (sb0.size() == 0) begin bad++; $display("FAIL rr_solo_sb act=empty exp=entry"); end
    else begin e = sb0.pop_front(); if ({s_adr_o, s_we_o, s_dat_o} !== e) begin bad++; $display("FAIL rr_solo_sb act=%h exp=%h", {s_adr_o, s_we_o, s_dat_o}, e); end end
    tick(); s_ack_i = 0; m0_cyc_i = 0; m0_stb_i = 0;
    tick();
    m0_cyc_i = 1; m0_stb_i = 1; m0_adr_i = 16'h0024; sb0.push_back({16'h0024, 1'b0, 32'h0});
    m1_cyc_i = 1; m1_stb_i = 1; m1_we_i = 1; m1_adr_i = 16'h0304; m1_dat_i = 32'hA5A5A5A5; sb1.push_back({16'h0304, 1'b1, 32'hA5A5A5A5});
    smp();
    total++; if (gnt_o !== 2'b00) begin bad++; $display("FAIL rr_idle act=%b exp=00", gnt_o); end
    tick(); s_ack_i = 1; smp();
    total++; if (gnt_o !== 2'b10) begin bad++; $display("FAIL rr_second_contention act=%b exp=10", gnt_o); end
    total++; if (sb1.size() == 0) begin bad++; $display("FAIL rr_sb1 act=empty exp=entry"); end
    else begin e = sb1.pop_front(); if ({s_adr_o, s_we_o, s_dat_o} !== e) begin bad++; $display("FAIL rr_sb1 act=%h exp=%h", {s_adr_o, s_we_o, s_dat_o}, e); end end
    tick(); s_ack_i = 0; m1_cyc_i = 0; m1_stb_i = 0; m1_we_i = 0;
    tick(); s_ack_i = 1; smp();
    total++; if (gnt_o !== 2'b01) begin bad++; $display("FAIL rr_follow act=%b exp=01", gnt_o); end
    total++; if (sb0.size() == 0) begin bad++; $display("FAIL rr_sb0 act=empty exp=entry"); end
    else begin e = sb0.pop_front(); if ({s_adr_o, s_we_o, s_dat_o} !== e) begin bad++; $display("FAIL rr_sb0 act=%h exp=%h", {s_adr_o, s_we_o, s_dat_o}, e); end end
    tick(); s_ack_i = 0; m0_cyc_i = 0; m0_stb_i = 0;
    tick();
  endtask

  task automatic test_data_write();
    tick(); m1_cyc_i = 1; m1_stb_i = 1; m1_we_i = 1; m1_adr_i = 16'h0200; m1_dat_i = 32'hDEADBEEF;
    sb1.push_back({16'h0200, 1'b1, 32'hDEADBEEF});
    tick(); m0_cyc_i = 1; m0_stb_i = 1; m0_adr_i = 16'h0044; sb0.push_back({16'h0044, 1'b0, 32'h0}); smp();
    total++; if (gnt_o !== 2'b10) begin bad++; $display("FAIL dw_gnt act=%b exp=10", gnt_o); end
    total++; if ({s_we_o, s_adr_o, s_dat_o} !== {1'b1, 16'h0200, 32'hDEADBEEF}) begin bad++; $display("FAIL dw_bus act=%b/%h/%h exp=1/0200/deadbeef", s_we_o, s_adr_o, s_dat_o); end
    tick(); smp();
    total++; if ({m0_ack_o, m1_ack_o} !== 2'b00) begin bad++; $display("FAIL dw_wait act=%b exp=00", {m0_ack_o, m1_ack_o}); end
    tick(); s_ack_i = 1; s_dat_i = 32'h0BADF00D; smp();
    total++; if ({m0_ack_o, m1_ack_o} !== 2'b01) begin bad++; $display("FAIL dw_ack act=%b exp=01", {m0_ack_o, m1_ack_o}); end
    total++; if (sb1.size() == 0) begin bad++; $display("FAIL dw_sb1 act=empty exp=entry"); end
    else begin e = sb1.pop_front(); if ({s_adr_o, s_we_o, s_dat_o} !== e) begin bad++; $display("FAIL dw_sb1 act=%h exp=%h", {s_adr_o, s_we_o, s_dat_o}, e); end end
    tick(); s_ack_i = 0; m1_cyc_i = 0; m1_stb_i = 0; m1_we_i = 0; smp();
    total++; if ({m0_ack_o, m1_ack_o} !== 2'b00) begin bad++; $display("FAIL dw_single_pulse act=%b exp=00", {m0_ack_o, m1_ack_o}); end
    tick(); s_ack_i = 1; smp();
    total++; if (gnt_o !== 2'b01) begin bad++; $display("FAIL dw_m0_next act=%b exp=01", gnt_o); end
    total++; if ({m0_ack_o, m1_ack_o} !== 2'b10) begin bad++; $display("FAIL dw_m0_ack act=%b exp=10", {m0_ack_o, m1_ack_o}); end
    total++; if (sb0.size() == 0) begin bad++; $display("FAIL dw_sb0 act=empty exp=entry"); end
    else begin e = sb0.pop_front(); if ({s_adr_o, s_we_o, s_dat_o} !== e) begin bad++; $display("FAIL dw_sb0 act=%h exp=%h", {s_adr_o, s_we_o, s_dat_o}, e); end end
    tick(); s_ack_i = 0; m0_cyc_i = 0; m0_stb_i = 0;
    tick();
  endtask

  task automatic test_lock();
    tick(); m1_cyc_i = 1; m1_stb_i = 1; m1_adr_i = 16'h0210; m1_dat_i = 32'h0; sb1.push_back({16'h0210, 1'b0, 32'h0});
    tick(); m0_cyc_i = 1; m0_stb_i = 1; m0_adr_i = 16'h0048; sb0.push_back({16'h0048, 1'b0, 32'h0});
    s_ack_i = 1; smp();
    total++; if (gnt_o !== 2'b10) begin bad++; $display("FAIL lock_gnt act=%b exp=10", gnt_o); end
    total++; if (sb1.size() == 0) begin bad++; $display("FAIL lock_sb1a act=empty exp=entry"); end
    else begin e = sb1.pop_front(); if ({s_adr_o, s_we_o, s_dat_o} !== e) begin bad++; $display("FAIL lock_sb1a act=%h exp=%h", {s_adr_o, s_we_o, s_dat_o}, e); end end
    tick(); s_ack_i = 0; m1_stb_i = 0; m1_adr_i = 16'h0214; smp();
    total++; if (gnt_o !== 2'b10) begin bad++; $display("FAIL lock_hold act=%b exp=10", gnt_o); end
    total++; if ({s_cyc_o, s_stb_o} !== 2'b10) begin bad++; $display("FAIL lock_gap act=%b exp=10", {s_cyc_o, s_stb_o}); end
    tick(); m1_stb_i = 1; sb1.push_back({16'h0214, 1'b0, 32'h0}); s_ack_i = 1; smp();
    total++; if ({gnt_o, m0_ack_o, m1_ack_o} !== 4'b1001) begin bad++; $display("FAIL lock_second act=%b exp=1001", {gnt_o, m0_ack_o, m1_ack_o}); end
    total++; if (sb1.size() == 0) begin bad++; $display("FAIL lock_sb1b act=empty exp=entry"); end
    else begin e = sb1.pop_front(); if ({s_adr_o, s_we_o, s_dat_o} !== e) begin bad++; $display("FAIL lock_sb1b act=%h exp=%h", {s_adr_o, s_we_o, s_dat_o}, e); end end
    tick(); s_ack_i = 0; m1_cyc_i = 0; m1_stb_i = 0; smp();
    total++; if (gnt_o !== 2'b10) begin bad++; $display("FAIL lock_release_cycle act=%b exp=10", gnt_o); end
    tick(); s_ack_i = 1; smp();
    total++; if ({gnt_o, m0_ack_o, m1_ack_o} !== 4'b0110) begin bad++; $display("FAIL lock_m0_after act=%b exp=0110", {gnt_o, m0_ack_o, m1_ack_o}); end
    total++; if (sb0.size() == 0) begin bad++; $display("FAIL lock_sb0 act=empty exp=entry"); end
    else begin e = sb0.pop_front(); if ({s_adr_o, s_we_o, s_dat_o} !== e) begin bad++; $display("FAIL lock_sb0 act=%h exp=%h", {s_adr_o, s_we_o, s_dat_o}, e); end end
    tick(); s_ack_i = 0; m0_cyc_i = 0; m0_stb_i = 0;
    tick();
  endtask

  task automatic test_timeout();
    // ack landing on the final count must win over the error
    tick(); m0_cyc_i = 1; m0_stb_i = 1; m0_adr_i = 16'h0030; sb0.push_back({16'h0030, 1'b0, 32'h0});
    tick(); tick(); tick(); smp();
    total++; if (m0_err_o !== 1'b0) begin bad++; $display("FAIL to_early_err act=%b exp=0", m0_err_o); end
    tick(); s_ack_i = 1; smp();
    total++; if ({m0_ack_o, m0_err_o} !== 2'b10) begin bad++; $display("FAIL to_ack_wins act=%b exp=10", {m0_ack_o, m0_err_o}); end
    total++; if (sb0.size() == 0) begin bad++; $display("FAIL to_sb0 act=empty exp=entry"); end
    else begin e = sb0.pop_front(); if ({s_adr_o, s_we_o, s_dat_o} !== e) begin bad++; $display("FAIL to_sb0 act=%h exp=%h", {s_adr_o, s_we_o, s_dat_o}, e); end end
    tick(); s_ack_i = 0; m0_cyc_i = 0; m0_stb_i = 0;
    tick(); m0_cyc_i = 1; m0_stb_i = 1; m0_adr_i = 16'h0034;
    tick(); smp();
    total++; if (gnt_o !== 2'b01) begin bad++; $display("FAIL to_gnt act=%b exp=01", gnt_o); end
    tick(); tick(); smp();
    total++; if (m0_err_o !== 1'b0) begin bad++; $display("FAIL to_pre_err act=%b exp=0", m0_err_o); end
    tick(); smp();
    total++; if ({m0_err_o, m1_err_o, s_cyc_o} !== 3'b101) begin bad++; $display("FAIL to_err_pulse act=%b exp=101", {m0_err_o, m1_err_o, s_cyc_o}); end
    tick(); smp();
    total++; if (m0_err_o !== 1'b0) begin bad++; $display("FAIL to_err_once act=%b exp=0", m0_err_o); end
    total++; if ({s_cyc_o, s_stb_o, gnt_o} !== 4'b0000) begin bad++; $display("FAIL to_cyc_drop act=%b exp=0000", {s_cyc_o, s_stb_o, gnt_o}); end
    tick(); m1_cyc_i = 1; m1_stb_i = 1; m1_adr_i = 16'h0338; sb1.push_back({16'h0338, 1'b0, 32'h0}); smp();
    total++; if (gnt_o !== 2'b01) begin bad++; $display("FAIL to_rearb act=%b exp=01", gnt_o); end
    tick(); tick(); tick(); smp();
    total++; if (m0_err_o !== 1'b1) begin bad++; $display("FAIL to_err_again act=%b exp=1", m0_err_o); end
    tick(); m0_cyc_i = 0; m0_stb_i = 0; s_ack_i = 1; smp();
    total++; if ({gnt_o, m0_err_o, m1_ack_o} !== 4'b1001) begin bad++; $display("FAIL to_pending_gnt act=%b exp=1001", {gnt_o, m0_err_o, m1_ack_o}); end
    total++; if (sb1.size() == 0) begin bad++; $display("FAIL to_sb1 act=empty exp=entry"); end
    else begin e = sb1.pop_front(); if ({s_adr_o, s_we_o, s_dat_o} !== e) begin bad++; $display("FAIL to_sb1 act=%h exp=%h", {s_adr_o, s_we_o, s_dat_o}, e); end end
    tick(); s_ack_i = 0; m1_cyc_i = 0; m1_stb_i = 0;
    tick(); smp();
    total++; if (gnt_o !== 2'b00) begin bad++; $display("FAIL to_idle act=%b exp=00", gnt_o); end
  endtask

  task automatic test_reset_mid();
    // leave M0 as last owner so only the reset can hand the next tie back to M0
    tick(); m0_cyc_i = 1; m0_stb_i = 1; m0_adr_i = 16'h0050; sb0.push_back({16'h0050, 1'b0, 32'h0});
    tick(); s_ack_i = 1; smp();
    total++; if (sb0.size() == 0) begin bad++; $display("FAIL rm_sb0a act=empty exp=entry"); end
    else begin e = sb0.pop_front(); if ({s_adr_o, s_we_o, s_dat_o} !== e) begin bad++; $display("FAIL rm_sb0a act=%h exp=%h", {s_adr_o, s_we_o, s_dat_o}, e); end end
    tick(); s_ack_i = 0; m0_cyc_i = 0; m0_stb_i = 0;
    tick(); m1_cyc_i = 1; m1_stb_i = 1; m1_we_i = 1; m1_adr_i = 16'h0400; m1_dat_i = 32'h12345678;
    tick(); smp();
    total++; if ({gnt_o, s_cyc_o} !== 3'b101) begin bad++; $display("FAIL rm_gnt1 act=%b exp=101", {gnt_o, s_cyc_o}); end
    tick(); rst = 1; smp();
    total++; if (gnt_o !== 2'b10) begin bad++; $display("FAIL rm_sync act=%b exp=10", gnt_o); end
    tick(); rst = 0; m0_cyc_i = 1; m0_stb_i = 1; m0_adr_i = 16'h0058; sb0.push_back({16'h0058, 1'b0, 32'h0}); smp();
    total++; if ({gnt_o, s_cyc_o, s_stb_o, s_we_o} !== 5'b0) begin bad++; $display("FAIL rm_ctl act=%b exp=00000", {gnt_o, s_cyc_o, s_stb_o, s_we_o}); end
    total++; if ({s_adr_o, s_dat_o} !== '0) begin bad++; $display("FAIL rm_bus act=%h/%h exp=0", s_adr_o, s_dat_o); end
    total++; if ({m0_ack_o, m1_ack_o, m0_err_o, m1_err_o} !== 4'b0000) begin bad++; $display("FAIL rm_ackerr act=%b exp=0000", {m0_ack_o, m1_ack_o, m0_err_o, m1_err_o}); end
    tick(); s_ack_i = 1; smp();
    total++; if (gnt_o !== 2'b01) begin bad++; $display("FAIL rm_m0_wins act=%b exp=01", gnt_o); end
    total++; if (sb0.size() == 0) begin bad++; $display("FAIL rm_sb0b act=empty exp=entry"); end
    else begin e = sb0.pop_front(); if ({s_adr_o, s_we_o, s_dat_o} !== e) begin bad++; $display("FAIL rm_sb0b act=%h exp=%h", {s_adr_o, s_we_o, s_dat_o}, e); end end
    tick(); idle_inputs();
    tick(); smp();
    total++; if (gnt_o !== 2'b00) begin bad++; $display("FAIL rm_idle act=%b exp=00", gnt_o); end
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog act=timeout exp=finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    test_reset();
    test_fetch();
    test_contention();
    test_round_robin();
    test_data_write();
    test_lock();
    test_timeout();
    test_reset_mid();
    total++;
    if (sb0.size() + sb1.size() != 0) begin
      bad++;
      $display("FAIL sb_drain act=%0d exp=0", sb0.size() + sb1.size());
    end
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/mem_bus_arbiter.md
Name: mem_bus_arbiter

Overview:
- Shares a single Wishbone-style memory slave between two masters: the control unit's instruction-fetch port (M0: stb/cyc, inst_ack) and its data port (M1: data_stb/data_cyc/data_we, data_ack).
- Registered grant FSM with round-robin arbitration on contention and grant locking for the whole bus cycle.
- Per-transfer ack timeout, so a dead slave cannot hang the multicycle FSM.
- Sits between the control unit/datapath and the unified instruction/data memory.

Parameters:
- ADDR_W, 16, address width of both masters and the slave.
- DATA_W, 32, data width.
- TIMEOUT_CYC, 255, cycles with stb high and no ack before an error is raised; 0 disables the timeout.

Ports:
- clk  in  1  clock
- rst  in  1  synchronous reset, active-high
- m0_cyc_i  in  1  fetch master cycle request
- m0_stb_i  in  1  fetch master strobe
- m0_adr_i  in  ADDR_W  fetch address
- m0_ack_o  out  1  fetch acknowledge
- m0_err_o  out  1  fetch timeout error, 1-cycle pulse
- m1_cyc_i  in  1  data master cycle request
- m1_stb_i  in  1  data master strobe
- m1_we_i  in  1  data master write enable
- m1_adr_i  in  ADDR_W  data address
- m1_dat_i  in  DATA_W  data master write data
- m1_ack_o  out  1  data acknowledge
- m1_err_o  out  1  data timeout error, 1-cycle pulse
- s_cyc_o  out  1  slave cycle
- s_stb_o  out  1  slave strobe
- s_we_o  out  1  slave write enable
- s_adr_o  out  ADDR_W  slave address
- s_dat_o  out  DATA_W  slave write data
- s_ack_i  in  1  slave acknowledge
- s_dat_i  in  DATA_W  slave read data
- m_dat_o  out  DATA_W  read data broadcast to both masters
- gnt_o  out  2  one-hot grant: bit0 = M0, bit1 = M1

Behaviour:
- FSM states:
  - IDLE: no grant.
  - GNT0: M0 owns the bus.
  - GNT1: M1 owns the bus.
- Reset:
  - State IDLE, last_gnt = M1 (so M0 wins the first contention), timeout counter 0.
  - All outputs 0.
- IDLE transitions:
  - Only M0 cyc high -> GNT0 next cycle.
  - Only M1 cyc high -> GNT1 next cycle.
  - Both high -> grant the master not equal to last_gnt.
  - Neither -> stay IDLE.
- Arbitration latency: exactly 1 cycle from request (cyc rising in IDLE) to s_cyc_o.
- In GNTx:
  - s_cyc_o = mx_cyc_i and s_stb_o = mx_stb_i, combinational from the owner.
  - s_adr_o / s_we_o / s_dat_o muxed from the owner.
  - M0 drives we = 0 and dat = 0.
- In IDLE: all s_* outputs are 0.
- Acknowledge routing:
  - mx_ack_o = s_ack_i & gnt_o[x] & mx_stb_i, combinational, zero added latency.
  - The non-owner ack is always 0.
- m_dat_o = s_dat_i, unconditionally.
- Grant lock and release:
  - Ownership holds while the owner's cyc is high, even across multiple strobes.
  - When the owner's cyc is sampled low: last_gnt <- owner.
    - If the other master's cyc is high, go directly to its GNT state (no IDLE bubble).
    - Otherwise go to IDLE.
- Timeout:
  - Counter clears on ack, on state change, and whenever owner stb is low.
  - It increments each cycle in GNTx with owner stb high and no s_ack_i.
  - When counter == TIMEOUT_CYC-1 with no ack that cycle:
    - Pulse mx_err_o for 1 cycle.
    - Force s_cyc_o/s_stb_o low the next cycle.
    - last_gnt <- owner; go to IDLE, or to the other master's GNT if it is requesting.
  - A requester that keeps cyc high after an error is re-arbitrated normally.
  - ack and timeout in the same cycle: ack wins, no err.
- Simultaneous owner release and new request from the same master: release is honoured. If the other master is requesting, it wins; otherwise the same master is re-granted via IDLE.
- Reset mid-transfer: state goes IDLE on the next edge and s_cyc_o drops. Masters must tolerate the aborted cycle (the control unit is reset by the same rst).
- gnt_o is registered state decode; never both bits set.

Decomposition:
- Package mem_bus_pkg holds:
  - typedef enum logic [1:0] {ARB_IDLE, ARB_GNT0, ARB_GNT1} arb_state_t;
  - localparams M_FETCH = 0 and M_DATA = 1.
- The timeout counter is a natural sub-module: bus_timeout_counter (params WIDTH, LIMIT; inputs clr, en; output expire).
- Arbiter FSM and muxes stay in mem_bus_arbiter.

Test Plan:
- Fetch only: m0_cyc/stb = 1, adr = 0x0010 at cycle 0. Expect gnt_o = 01 and s_cyc_o = 1 with s_adr_o = 0x0010 at cycle 1. Slave acks at cycle 3 -> m0_ack_o = 1 at cycle 3, m1_ack_o = 0. m0_cyc drops at cycle 4 -> IDLE at cycle 5.
- Contention after reset: M0 and M1 both raise cyc at the same cycle. M0 is granted first. On M0 release, M1 is granted the very next cycle with no IDLE bubble. Next contention grants M1 first (round robin).
- Data write: m1_we = 1, adr = 0x0200, dat = 0xDEADBEEF. Expect s_we_o = 1, s_adr_o = 0x0200, s_dat_o = 0xDEADBEEF. Ack after 2 wait cycles -> m1_ack_o pulses once. M0 sees no ack during the transfer.
- Lock: M1 holds cyc across two strobes while M0 requests. M0 is not granted until M1 drops cyc.
- Timeout: TIMEOUT_CYC = 4, M0 granted, slave never acks. Expect m0_err_o high for exactly 1 cycle, s_cyc_o = 0 the following cycle, and M1 granted if it is pending.
- Reset mid-transfer: rst asserted while in GNT1. Expect all outputs 0 and gnt_o = 00 on the next edge. After reset, contention is won by M0.
